// File: rtl/lcd_raw_pkg.sv
// Shared types and defaults for the raw 4-bit monochrome LCD bus capture path.
package lcd_raw_pkg;

  localparam int unsigned ResXDef = 320;
  localparam int unsigned ResYDef = 200;
  localparam int unsigned NplDef  = ResXDef / 4;

  // Synchronised bus vector layout
  localparam int unsigned FlmBit  = 4;
  localparam int unsigned LpBit   = 5;
  localparam int unsigned DclkBit = 6;
  localparam int unsigned MBit    = 7;

  typedef enum logic {
    StHunt,
    StLine
  } cap_state_e;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Two-flop synchroniser for the LCD bus plus one edge stage producing LP/DCLK fall strobes.
module lcd_in_sync
  import lcd_raw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_i,
  input  logic       flm_i,
  input  logic       lp_i,
  input  logic       dclk_i,
  input  logic       m_i,
  output logic [3:0] data_o,
  output logic       flm_o,
  output logic       m_o,
  output logic       lp_fall_o,
  output logic       dclk_fall_o
);

  logic [7:0] meta_q, meta_d;
  logic [7:0] sync_q, sync_d;
  logic [1:0] edge_q, edge_d;

  always_comb begin
    meta_d = {m_i, dclk_i, lp_i, flm_i, data_i};
    sync_d = meta_q;
    edge_d = {sync_q[DclkBit], sync_q[LpBit]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // Strobes are aligned with the sync_q levels, so data/FLM/M are taken from the same stage.
  assign data_o      = sync_q[3:0];
  assign flm_o       = sync_q[FlmBit];
  assign m_o         = sync_q[MBit];
  assign lp_fall_o   = edge_q[0] & ~sync_q[LpBit];
  assign dclk_fall_o = edge_q[1] & ~sync_q[DclkBit];

endmodule

// File: rtl/lcd_bus_capture.sv
// Captures a raw 4-bit LCD bus into framebuffer byte writes, tracking frame/line/column
// position and flagging nibble-count, row-count and AC-phase errors.
module lcd_bus_capture
  import lcd_raw_pkg::*;
#(
  parameter int unsigned RES_X   = ResXDef,
  parameter int unsigned RES_Y   = ResYDef,
  parameter int unsigned ADDR_W  = 16,
  parameter bit          BIT_REV = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic [3:0]        lcd_data,
  input  logic              lcd_flm,
  input  logic              lcd_lp,
  input  logic              lcd_dclk,
  input  logic              lcd_m,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              line_err,
  output logic              frame_err,
  output logic              m_err
);

  localparam int unsigned Npl  = RES_X / 4;
  localparam int unsigned Bpl  = RES_X / 8;
  localparam int unsigned NibW = $clog2(Npl + 2);
  localparam int unsigned RowW = $clog2(RES_Y + 1);

  logic [3:0] data_s;
  logic       flm_s, m_s, lp_fall, dclk_fall;

  lcd_in_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (lcd_data),
    .flm_i      (lcd_flm),
    .lp_i       (lcd_lp),
    .dclk_i     (lcd_dclk),
    .m_i        (lcd_m),
    .data_o     (data_s),
    .flm_o      (flm_s),
    .m_o        (m_s),
    .lp_fall_o  (lp_fall),
    .dclk_fall_o(dclk_fall)
  );

  cap_state_e        state_q, state_d;
  logic              locked_q, locked_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [NibW-1:0]   nib_q, nib_d;
  logic [3:0]        hi_q, hi_d;
  logic              m_last_q, m_last_d, m_valid_q, m_valid_d;
  logic              pend_q, pend_d, pend_last_q, pend_last_d;
  logic [7:0]        pend_byte_q, pend_byte_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              line_err_q, line_err_d, frame_err_q, frame_err_d, m_err_q, m_err_d;
  logic [ADDR_W-1:0] byte_addr;

  assign byte_addr = ADDR_W'(row_q) * ADDR_W'(Bpl) + ADDR_W'(nib_q >> 1);

  always_comb begin
    state_d      = state_q;
    locked_d     = locked_q;
    row_d        = row_q;
    nib_d        = nib_q;
    hi_d         = hi_q;
    m_last_d     = m_last_q;
    m_valid_d    = m_valid_q;
    pend_d       = 1'b0;
    pend_last_d  = pend_last_q;
    pend_byte_d  = pend_byte_q;
    pend_addr_d  = pend_addr_q;
    wr_en_d      = pend_q & cap_en;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    line_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    m_err_d      = 1'b0;

    // Second pipeline stage: a byte assembled last cycle is presented on the write port.
    if (pend_q && cap_en) begin
      wr_addr_d    = pend_addr_q;
      wr_data_d    = BIT_REV ? bit_rev8(pend_byte_q) : pend_byte_q;
      frame_done_d = pend_last_q;
    end

    if (!cap_en) begin
      state_d  = StHunt;
      locked_d = 1'b0;
      nib_d    = '0;
    end else begin
      case (state_q)
        StHunt: begin
          if (lp_fall && flm_s) begin
            state_d   = StLine;
            locked_d  = 1'b1;
            row_d     = '0;
            nib_d     = '0;
            m_last_d  = m_s;
            m_valid_d = 1'b1;
          end
        end
        StLine: begin
          if (lp_fall) begin
            // Line start takes priority over a coincident DCLK fall; that nibble is lost.
            nib_d      = '0;
            line_err_d = (nib_q != NibW'(Npl));
            if (flm_s) begin
              frame_err_d = (row_q != RowW'(RES_Y - 1));
              m_err_d     = m_valid_q && (m_s == m_last_q);
              m_last_d    = m_s;
              m_valid_d   = 1'b1;
              row_d       = '0;
            end else if (row_q == RowW'(RES_Y - 1)) begin
              frame_err_d = 1'b1;
              locked_d    = 1'b0;
              state_d     = StHunt;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else if (dclk_fall) begin
            if (nib_q < NibW'(Npl)) begin
              nib_d = nib_q + 1'b1;
              if (!nib_q[0]) begin
                hi_d = data_s;
              end else begin
                pend_d      = 1'b1;
                pend_byte_d = {hi_q, data_s};
                pend_addr_d = byte_addr;
                pend_last_d = (row_q == RowW'(RES_Y - 1)) && (nib_q == NibW'(Npl - 1));
              end
            end else if (nib_q == NibW'(Npl)) begin
              // Saturate one past NPL so an over-long line still reports line_err.
              nib_d = nib_q + 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      locked_q     <= 1'b0;
      row_q        <= '0;
      nib_q        <= '0;
      hi_q         <= '0;
      m_last_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_byte_q  <= '0;
      pend_addr_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      m_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_q     <= locked_d;
      row_q        <= row_d;
      nib_q        <= nib_d;
      hi_q         <= hi_d;
      m_last_q     <= m_last_d;
      m_valid_q    <= m_valid_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      pend_byte_q  <= pend_byte_d;
      pend_addr_q  <= pend_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      m_err_q      <= m_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign m_err      = m_err_q;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Self-checking bench: table of LCD lines with expected flags, scoreboard of expected writes.
module tb_lcd_bus_capture;

  localparam int unsigned ResX  = 32;
  localparam int unsigned ResY  = 4;
  localparam int unsigned Npl   = ResX / 4;
  localparam int unsigned Bpl   = ResX / 8;
  localparam int unsigned AddrW = 16;

  logic             clk = 1'b0;
  logic             rst_n, cap_en;
  logic [3:0]       lcd_data;
  logic             lcd_flm, lcd_lp, lcd_dclk, lcd_m;
  logic             wr_en, frame_done, locked, line_err, frame_err, m_err;
  logic [AddrW-1:0] wr_addr;
  logic [7:0]       wr_data;

  always #5 clk = ~clk;

  lcd_bus_capture #(
    .RES_X  (ResX),
    .RES_Y  (ResY),
    .ADDR_W (AddrW),
    .BIT_REV(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .lcd_data  (lcd_data),
    .lcd_flm   (lcd_flm),
    .lcd_lp    (lcd_lp),
    .lcd_dclk  (lcd_dclk),
    .lcd_m     (lcd_m),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .locked    (locked),
    .line_err  (line_err),
    .frame_err (frame_err),
    .m_err     (m_err)
  );

  typedef struct {
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
    logic             done;
  } wr_t;

  typedef struct {
    logic flm;
    logic m;
    int   nnib;
    int   drop;   // nibbles sent before cap_en drops, -1 = never
    int   wrow;   // row the writes must land in, -1 = no writes
    int   le, fe, me, fd;
    logic lk;
  } vec_t;

  wr_t  sb[$];
  wr_t  mon_e;
  vec_t tbl[22];
  int   checks = 0, failures = 0;
  int   n_le = 0, n_fe = 0, n_me = 0, n_fd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  function automatic vec_t mk(input int flm, input int m, input int nnib, input int drop,
                              input int wrow, input int le, input int fe, input int me,
                              input int fd, input int lk);
    vec_t r;
    r.flm = (flm != 0); r.m = (m != 0); r.nnib = nnib; r.drop = drop; r.wrow = wrow;
    r.le = le; r.fe = fe; r.me = me; r.fd = fd; r.lk = (lk != 0);
    return r;
  endfunction

  // Output monitor: counts pulses and pops the scoreboard on every write.
  always @(negedge clk) begin
    if (line_err) n_le++;
    if (frame_err) n_fe++;
    if (m_err) n_me++;
    if (frame_done) n_fd++;
    if (wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
        check("frame_done_with_write", 32'(frame_done), 32'(mon_e.done));
      end
    end else if (frame_done) begin
      check("frame_done_without_write", 32'(frame_done), 32'(0));
    end
  end

  // All drive tasks are entered and left on a falling clk edge.
  task automatic line_start(input logic flm, input logic m);
    lcd_lp = 1'b1; lcd_flm = flm; lcd_m = m;
    repeat (2) @(negedge clk);
    lcd_lp = 1'b0;
    repeat (3) @(negedge clk);
    lcd_flm = 1'b0;
  endtask

  task automatic nibble(input logic [3:0] v);
    lcd_data = v; lcd_dclk = 1'b1;
    repeat (2) @(negedge clk);
    lcd_dclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input int row, input int idx, input logic [3:0] hi, input logic [3:0] lo);
    wr_t e;
    e.addr = AddrW'(row * int'(Bpl) + idx / 2);
    e.data = rev8({hi, lo});
    e.done = (row == int'(ResY) - 1) && (idx == int'(Npl) - 1);
    sb.push_back(e);
  endtask

  task automatic send_row(input logic flm, input logic m, input int nnib, input int drop,
                          input int wrow);
    logic [3:0] hi, v;
    hi = 4'h0;
    line_start(flm, m);
    for (int i = 0; i < nnib; i++) begin
      v = 4'($urandom_range(0, 15));
      if ((i % 2 == 1) && (i < int'(Npl)) && (wrow >= 0) && (drop < 0 || i < drop))
        push(wrow, i, hi, v);
      if (i % 2 == 0) hi = v;
      nibble(v);
      if (i + 1 == drop) cap_en = 1'b0;
    end
    repeat (4) @(negedge clk);
    cap_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int le0, fe0, me0, fd0;
    logic [3:0] v0, v1, v2, v3;

    //            flm m nnib drop wrow le fe me fd lk
    tbl[0]  = mk(1, 0, 8, -1,  0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 8, -1,  1, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 8, -1,  2, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 8, -1,  3, 0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 1, 8, -1,  0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 1, 7, -1,  1, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 1, 8, -1,  2, 1, 0, 0, 0, 1);
    tbl[7]  = mk(0, 1, 8, -1,  3, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1, 1, 8, -1,  0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(0, 1, 8, -1,  1, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 1, 8, -1,  2, 0, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 8, -1,  0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 9, -1,  1, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 8, -1,  2, 1, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 8, -1,  3, 0, 0, 0, 1, 1);
    tbl[15] = mk(0, 0, 8, -1, -1, 0, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 8, -1, -1, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 8, -1,  0, 0, 0, 0, 0, 1);
    tbl[18] = mk(0, 0, 8,  3,  1, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 8, -1, -1, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 1, 8, -1,  0, 0, 0, 0, 0, 1);
    tbl[21] = mk(0, 1, 8, -1,  1, 0, 0, 0, 0, 1);

    rst_n = 1'b0; cap_en = 1'b1; lcd_data = 4'h0;
    lcd_flm = 1'b0; lcd_lp = 1'b0; lcd_dclk = 1'b0; lcd_m = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", 32'(wr_en), 32'(0));
    check("reset_wr_addr", 32'(wr_addr), 32'(0));
    check("reset_wr_data", 32'(wr_data), 32'(0));
    check("reset_locked", 32'(locked), 32'(0));
    check("reset_errs", 32'({line_err, frame_err, m_err, frame_done}), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      le0 = n_le; fe0 = n_fe; me0 = n_me; fd0 = n_fd;
      send_row(tbl[i].flm, tbl[i].m, tbl[i].nnib, tbl[i].drop, tbl[i].wrow);
      check($sformatf("row%0d_line_err", i), 32'(n_le - le0), 32'(tbl[i].le));
      check($sformatf("row%0d_frame_err", i), 32'(n_fe - fe0), 32'(tbl[i].fe));
      check($sformatf("row%0d_m_err", i), 32'(n_me - me0), 32'(tbl[i].me));
      check($sformatf("row%0d_frame_done", i), 32'(n_fd - fd0), 32'(tbl[i].fd));
      check($sformatf("row%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      check($sformatf("row%0d_writes_drained", i), 32'(sb.size()), 32'(0));
    end

    // Write latency: wr_en rises on the 4th rising edge counting the one that first sees DCLK low.
    line_start(1'b0, 1'b1);
    v0 = 4'($urandom_range(0, 15));
    v1 = 4'($urandom_range(0, 15));
    nibble(v0);
    lcd_data = v1; lcd_dclk = 1'b1;
    repeat (2) @(negedge clk);
    push(2, 1, v0, v1);
    lcd_dclk = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", k), 32'(wr_en), 32'(k == 4));
    end
    @(negedge clk);

    // Reset in the middle of a row, with a half byte held.
    v2 = 4'($urandom_range(0, 15));
    v3 = 4'($urandom_range(0, 15));
    push(2, 3, v2, v3);
    nibble(v2);
    nibble(v3);
    nibble(4'hA);
    repeat (4) @(negedge clk);
    check("midrow_sb_drained", 32'(sb.size()), 32'(0));
    rst_n = 1'b0;
    #1;
    check("midrow_rst_locked", 32'(locked), 32'(0));
    check("midrow_rst_wr_addr", 32'(wr_addr), 32'(0));
    check("midrow_rst_wr_data", 32'(wr_data), 32'(0));
    check("midrow_rst_strobes",
          32'({wr_en, frame_done, line_err, frame_err, m_err}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) nibble(4'($urandom_range(0, 15)));
    le0 = n_le; fe0 = n_fe; me0 = n_me;
    send_row(1'b0, 1'b1, 8, -1, -1);
    check("post_rst_noflm_locked", 32'(locked), 32'(0));
    send_row(1'b1, 1'b1, 8, -1, 0);
    check("post_rst_flm_locked", 32'(locked), 32'(1));
    check("post_rst_errs", 32'((n_le - le0) + (n_fe - fe0) + (n_me - me0)), 32'(0));
    check("final_sb_drained", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
